// File: rtl/note_player_nharm_pkg.sv
// Shared constants, FSM state encoding and the output clamp for the harmonic note player.
package note_player_nharm_pkg;
  localparam int NOTE_W      = 6;
  localparam int SINE_ADDR_W = 10;
  localparam int SAMPLE_W    = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/dffre.sv
// Register with synchronous active-high reset and load enable.
module dffre #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (r)       q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/frequency_rom.sv
// Note index to phase step (equal temperament, note 49 = A440, 48 kHz sample rate), registered output.
module frequency_rom #(
  parameter int PHASE_W = 20
) (
  input  logic               clk,
  input  logic [5:0]         addr,
  output logic [PHASE_W-1:0] dout
);
  function automatic int step_of(input int n);
    real f;
    if (n == 0) return 0;
    f = 440.0 * (2.0 ** ((n - 49) / 12.0)) * (2.0 ** PHASE_W) / 48000.0;
    return $rtoi(f + 0.5);
  endfunction

  logic [PHASE_W-1:0] rom [64];

  for (genvar i = 0; i < 64; i++) begin : g_rom
    localparam logic [PHASE_W-1:0] V = PHASE_W'(step_of(i));
    assign rom[i] = V;
  end

  always_ff @(posedge clk) dout <= rom[addr];
endmodule

// File: rtl/note_player_nharm_sine.sv
// Registered full-wave sine table shared by all harmonics; one cycle from address to data.
module harmonic_sine_lookup #(
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic [ADDR_W-1:0]          addr,
  output logic signed [SAMPLE_W-1:0] data
);
  localparam int DEPTH = 1 << ADDR_W;

  function automatic int sine_entry(input int i);
    real x;
    x = (2.0 ** (SAMPLE_W - 1) - 1.0) * $sin(2.0 * 3.14159265358979 * i / DEPTH);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return $rtoi(x - 0.5);
  endfunction

  logic signed [SAMPLE_W-1:0] table_w [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tab
    localparam logic signed [SAMPLE_W-1:0] V = SAMPLE_W'(sine_entry(i));
    assign table_w[i] = V;
  end

  always_ff @(posedge clk) data <= table_w[addr];
endmodule

// File: rtl/note_player_nharm.sv
// Note player summing NUM_HARM gain-weighted harmonics through one time-multiplexed sine lookup.
module note_player_nharm import note_player_nharm_pkg::*; #(
  parameter int NUM_HARM = 3,
  parameter int PHASE_W  = 20,
  parameter int ADDR_W   = 10,
  parameter int SAMPLE_W = 16,
  parameter int DUR_W    = 6,
  parameter int GAIN_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play_enable,
  input  logic [NOTE_W-1:0]            note_to_load,
  input  logic [DUR_W-1:0]             duration_to_load,
  input  logic                         load_new_note,
  output logic                         done_with_note,
  input  logic                         beat,
  input  logic [NUM_HARM*GAIN_W-1:0]   harm_gain,
  input  logic                         generate_next_sample,
  output logic [SAMPLE_W-1:0]          sample_out,
  output logic                         new_sample_ready
);
  localparam int ACC_W = SAMPLE_W + GAIN_W + $clog2(NUM_HARM) + 1;
  localparam int K_W   = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;

  state_t                     state;
  logic [NOTE_W-1:0]          note_q;
  logic [NOTE_W-1:0]          rom_addr;
  logic [PHASE_W-1:0]         step;
  logic [DUR_W-1:0]           dur_q;
  logic [K_W-1:0]             k_q;
  logic [K_W-1:0]             k_d;
  logic                       rd_valid;
  logic                       pending_zero;
  logic                       zero_phases;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    term;
  logic signed [31:0]         acc_shift;
  logic signed [SAMPLE_W-1:0] sine_data;
  logic [ADDR_W-1:0]          rd_addr;
  logic [GAIN_W-1:0]          gain_sel;
  logic [PHASE_W-1:0]         phase      [NUM_HARM];
  logic [PHASE_W-1:0]         phase_next [NUM_HARM];
  logic [NUM_HARM-1:0]        phase_en;

  dffre #(.WIDTH(NOTE_W)) u_note (
    .clk(clk), .r(reset), .en(load_new_note), .d(note_to_load), .q(note_q)
  );

  // Look up the incoming note on a load so the step is ready the cycle after the strobe.
  assign rom_addr = load_new_note ? note_to_load : note_q;

  frequency_rom #(.PHASE_W(PHASE_W)) u_freq (.clk(clk), .addr(rom_addr), .dout(step));

  always_ff @(posedge clk) begin
    if (reset)                                        dur_q <= '0;
    else if (load_new_note)                           dur_q <= duration_to_load;
    else if (beat && play_enable && dur_q != '0)      dur_q <= dur_q - 1'b1;
  end

  assign done_with_note = !reset && beat && play_enable && (dur_q == '0) && !load_new_note;

  // A new note restarts every harmonic at phase 0; a busy FSM defers this to its OUTPUT cycle.
  assign zero_phases = (load_new_note && state == IDLE) ||
                       (state == OUTPUT && (pending_zero || load_new_note));

  for (genvar h = 0; h < NUM_HARM; h++) begin : g_phase
    localparam logic [PHASE_W-1:0] MULT = PHASE_W'(h + 1);
    logic [PHASE_W-1:0] inc;
    assign inc           = step * MULT;
    assign phase_next[h] = zero_phases ? '0 : phase[h] + inc;
    assign phase_en[h]   = zero_phases || (state == ISSUE && k_q == K_W'(h));
    dffre #(.WIDTH(PHASE_W)) u_phase (
      .clk(clk), .r(reset), .en(phase_en[h]), .d(phase_next[h]), .q(phase[h])
    );
  end

  assign rd_addr = phase[k_q][PHASE_W-1 -: ADDR_W];

  harmonic_sine_lookup #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) u_sine (
    .clk(clk), .addr(rd_addr), .data(sine_data)
  );

  assign gain_sel  = harm_gain[k_d*GAIN_W +: GAIN_W];
  assign term      = ACC_W'(sine_data) * ACC_W'($signed({1'b0, gain_sel}));
  assign acc_shift = 32'(acc >>> GAIN_W);

  // k_d / rd_valid trail the issue index by the lookup latency so each datum meets its own gain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      k_q              <= '0;
      k_d              <= '0;
      rd_valid         <= 1'b0;
      acc              <= '0;
      pending_zero     <= 1'b0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      new_sample_ready <= 1'b0;
      rd_valid         <= (state == ISSUE);
      k_d              <= k_q;
      if (rd_valid) acc <= acc + term;
      case (state)
        IDLE: begin
          if (generate_next_sample && play_enable) begin
            state <= ISSUE;
            k_q   <= '0;
            acc   <= '0;
          end
        end
        ISSUE: begin
          if (load_new_note) pending_zero <= 1'b1;
          if (k_q == K_W'(NUM_HARM - 1)) begin
            k_q   <= '0;
            state <= DRAIN;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DRAIN: begin
          if (load_new_note) pending_zero <= 1'b1;
          state <= OUTPUT;
        end
        OUTPUT: begin
          sample_out       <= SAMPLE_W'(saturate(acc_shift, SAMPLE_W));
          new_sample_ready <= 1'b1;
          pending_zero     <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_note_player_nharm.sv
// Randomised bench for note_player_nharm: sample scoreboard against an arithmetic model, plus duration checks.
module tb_note_player_nharm;
  localparam int NUM_HARM = 3;
  localparam int PHASE_W  = 20;
  localparam int ADDR_W   = 10;
  localparam int SAMPLE_W = 16;
  localparam int DUR_W    = 6;
  localparam int GAIN_W   = 4;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       play_enable = 1'b0;
  logic [5:0]                 note_to_load = '0;
  logic [DUR_W-1:0]           duration_to_load = '0;
  logic                       load_new_note = 1'b0;
  logic                       done_with_note;
  logic                       beat = 1'b0;
  logic [NUM_HARM*GAIN_W-1:0] harm_gain = '0;
  logic                       generate_next_sample = 1'b0;
  logic [SAMPLE_W-1:0]        sample_out;
  logic                       new_sample_ready;

  note_player_nharm #(
    .NUM_HARM(NUM_HARM), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W),
    .SAMPLE_W(SAMPLE_W), .DUR_W(DUR_W), .GAIN_W(GAIN_W)
  ) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load),
    .load_new_note(load_new_note), .done_with_note(done_with_note),
    .beat(beat), .harm_gain(harm_gain),
    .generate_next_sample(generate_next_sample),
    .sample_out(sample_out), .new_sample_ready(new_sample_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int m_dur = 0;
  int m_step = 0;
  int m_phase [NUM_HARM];
  logic [SAMPLE_W-1:0] exp_q[$];
  int exp_cyc_q[$];
  bit count_sat = 1'b0;
  int sat_hi = 0;
  int sat_lo = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int sine_ref(input int a);
    real x;
    x = 32767.0 * $sin(2.0 * 3.14159265358979 * a / 1024.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return $rtoi(x - 0.5);
  endfunction

  function automatic int step_ref(input int n);
    real f;
    if (n == 0) return 0;
    f = 440.0 * (2.0 ** ((n - 49) / 12.0)) * 1048576.0 / 48000.0;
    return $rtoi(f + 0.5);
  endfunction

  // Mixed sample from the current phases, then advance each harmonic by (k+1)*step.
  function automatic logic [SAMPLE_W-1:0] model_sample();
    int sum;
    int s;
    int g;
    sum = 0;
    for (int k = 0; k < NUM_HARM; k++) begin
      g = int'(harm_gain[k*GAIN_W +: GAIN_W]);
      sum += sine_ref(m_phase[k] >> (PHASE_W - ADDR_W)) * g;
      m_phase[k] = (m_phase[k] + (k + 1) * m_step) & ((1 << PHASE_W) - 1);
    end
    s = sum >>> GAIN_W;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return SAMPLE_W'(s);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset)                                   m_dur = 0;
    else if (load_new_note)                      m_dur = int'(duration_to_load);
    else if (beat && play_enable && m_dur != 0)  m_dur--;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic zero_model_phases();
    for (int k = 0; k < NUM_HARM; k++) m_phase[k] = 0;
  endtask

  task automatic load_note(input int n, input int d);
    note_to_load     = 6'(n);
    duration_to_load = DUR_W'(d);
    load_new_note    = 1'b1;
    m_step = step_ref(n);
    zero_model_phases();
    tick();
    load_new_note = 1'b0;
  endtask

  task automatic request();
    generate_next_sample = 1'b1;
    if (play_enable) begin
      exp_q.push_back(model_sample());
      exp_cyc_q.push_back(cyc + 6);
    end
    tick();
    generate_next_sample = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got no pulse expected %0d pending samples", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    tick();
  endtask

  task automatic beat_pulse(output logic d);
    beat = 1'b1;
    #3;
    d = done_with_note;
    tick();
    beat = 1'b0;
    tick();
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [SAMPLE_W-1:0] e;
    int ec;
    if (new_sample_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("sample", int'($signed(sample_out)), int'($signed(e)));
        check("latency_cycle", cyc, ec);
        if (count_sat && $signed(sample_out) == 16'sh7fff) sat_hi++;
        if (count_sat && $signed(sample_out) == -16'sh8000) sat_lo++;
      end
    end
    if (beat || done_with_note || load_new_note)
      check("done_rule", int'(done_with_note),
            int'(!reset && beat && play_enable && m_dur == 0 && !load_new_note));
  end

  // ---------------- stimulus ----------------
  initial begin
    logic d;
    zero_model_phases();

    // Reset state, with beat/play asserted so done is genuinely gated by reset.
    reset = 1'b1; play_enable = 1'b1; beat = 1'b1;
    tick(); tick(); tick();
    check("reset_sample_out", int'(sample_out), 0);
    check("reset_ready", int'(new_sample_ready), 0);
    check("reset_done", int'(done_with_note), 0);
    beat = 1'b0;
    reset = 1'b0;
    tick();

    // Reset in the middle of a computation.
    harm_gain = 12'h9a7;
    load_note(40, 5);
    tick(); tick();
    request();
    tick();
    reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    tick(); tick();
    check("midreset_sample_out", int'(sample_out), 0);
    check("midreset_ready", int'(new_sample_ready), 0);
    reset = 1'b0;
    m_step = 0;
    zero_model_phases();
    tick(); tick(); tick();
    request();
    wait_idle();

    // Duration: 3 beats counted down, done on the 4th beat only.
    load_note(30, 3);
    for (int b = 1; b <= 4; b++) begin
      beat_pulse(d);
      check("dur_all_enabled", int'(d), int'(b == 4));
    end

    // Duration with play_enable low on beat 2: done moves to the 5th beat.
    load_note(30, 3);
    for (int b = 1; b <= 5; b++) begin
      play_enable = (b != 2);
      beat_pulse(d);
      check("dur_paused_beat", int'(d), int'(b == 5));
    end
    play_enable = 1'b1;

    // Load and beat together at count 0: no pulse, count becomes the new duration.
    note_to_load = 6'd30; duration_to_load = DUR_W'(7); load_new_note = 1'b1; beat = 1'b1;
    zero_model_phases();
    #3;
    check("load_beat_same_cycle", int'(done_with_note), 0);
    tick();
    load_new_note = 1'b0; beat = 1'b0;
    tick();
    for (int b = 1; b <= 8; b++) begin
      beat_pulse(d);
      check("dur_after_load_beat", int'(d), int'(b == 8));
    end

    // Single harmonic: only the fundamental at gain 15.
    harm_gain = {4'd0, 4'd0, 4'd15};
    load_note(1, 10);
    tick();
    for (int i = 0; i < 100; i++) begin
      request();
      wait_idle();
    end

    // Saturation sweep with every harmonic at full gain.
    harm_gain = {4'd15, 4'd15, 4'd15};
    load_note(60, 10);
    tick();
    count_sat = 1'b1;
    for (int i = 0; i < 500; i++) begin
      request();
      wait_idle();
    end
    count_sat = 1'b0;
    check("saturated_high_seen", int'(sat_hi > 0), 1);
    check("saturated_low_seen", int'(sat_lo > 0), 1);

    // Load while busy: in-flight sample uses old phases, the next one reads phase 0.
    harm_gain = 12'hb6d;
    load_note(45, 10);
    tick();
    for (int i = 0; i < 4; i++) begin
      request();
      wait_idle();
    end
    request();
    tick();
    load_note(52, 10);
    wait_idle();
    request();
    check("post_load_model_zero", int'(exp_q[exp_q.size()-1]), 0);
    wait_idle();

    // A request during a busy computation is ignored.
    request();
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    wait_idle();
    tick(); tick(); tick(); tick(); tick(); tick();

    // play_enable falling mid-computation still completes; a request while disabled is ignored.
    request();
    play_enable = 1'b0;
    wait_idle();
    request();
    tick(); tick(); tick(); tick(); tick(); tick(); tick();
    play_enable = 1'b1;

    // Randomised notes, gains, beats and enable.
    for (int i = 0; i < 150; i++) begin
      harm_gain = (NUM_HARM*GAIN_W)'($urandom);
      if ($urandom_range(0, 3) == 0)
        load_note(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
                  int'($urandom_range(0, 5)));
      if ($urandom_range(0, 2) == 0) begin
        play_enable = ($urandom_range(0, 3) != 0);
        beat_pulse(d);
        play_enable = 1'b1;
      end
      play_enable = ($urandom_range(0, 7) != 0);
      request();
      if ($urandom_range(0, 3) == 0) play_enable = 1'b0;
      wait_idle();
      play_enable = 1'b1;
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
    end

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
